// File: rtl/cpu_sequencer.sv
// Cycle sequencer for the Nandy core: fetch, one/two-cycle execute with memory
// wait stretching, interrupt entry at instruction boundaries, debug halt/step.
module cpu_sequencer #(
  parameter int unsigned TWO_CYC_BIT = 7,
  parameter int unsigned MEM_BIT     = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           inst_in,
  input  logic                 mem_ready,
  input  logic                 irq,
  input  logic                 ie_set,
  input  logic                 ie_clr,
  input  logic                 dbg_halt,
  input  logic                 dbg_step,
  output logic [7:0]           ir,
  output logic                 cycle,
  output logic                 mem_req,
  output logic                 fetch,
  output logic                 pc_inc,
  output logic                 commit,
  output logic                 int_entry,
  output logic                 irq_ack,
  output logic                 ie,
  output logic                 halted
);

  localparam int unsigned IW = 8;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC0 = 3'd1,
    S_EXEC1 = 3'd2,
    S_INT   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t        state, state_nxt;
  state_t        bnd_state;
  logic          bnd_clr_step;
  logic          step_pending, step_pending_nxt;
  logic [IW-1:0] ir_nxt;
  logic          ie_nxt;

  // Where to go once the current instruction retires
  always_comb begin
    bnd_state    = S_FETCH;
    bnd_clr_step = 1'b0;
    if (irq && ie && !ie_clr) begin
      bnd_state = S_INT;
    end else if (dbg_halt || step_pending) begin
      bnd_state    = S_HALT;
      bnd_clr_step = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_FETCH;
      ir           <= '0;
      cycle        <= 1'b0;
      ie           <= 1'b0;
      halted       <= 1'b0;
      step_pending <= 1'b0;
    end else begin
      state        <= state_nxt;
      ir           <= ir_nxt;
      cycle        <= (state_nxt == S_EXEC1);
      ie           <= ie_nxt;
      halted       <= (state_nxt == S_HALT);
      step_pending <= step_pending_nxt;
    end
  end

  // Next state and cycle strobes; strobes stay low during reset
  always_comb begin
    state_nxt        = state;
    ir_nxt           = ir;
    ie_nxt           = ie;
    step_pending_nxt = step_pending;
    mem_req          = 1'b0;
    fetch            = 1'b0;
    pc_inc           = 1'b0;
    commit           = 1'b0;
    int_entry        = 1'b0;
    irq_ack          = 1'b0;

    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          fetch   = 1'b1;
          if (mem_ready) begin
            pc_inc    = 1'b1;
            ir_nxt    = inst_in;
            state_nxt = S_EXEC0;
          end
        end

        S_EXEC0: begin
          if (!ir[TWO_CYC_BIT]) begin
            commit = 1'b1;
          end else begin
            mem_req = 1'b1;
            if (mem_ready) begin
              state_nxt = S_EXEC1;
            end
          end
        end

        S_EXEC1: begin
          if (!ir[MEM_BIT]) begin
            mem_req = 1'b1;
            commit  = mem_ready;
          end else begin
            commit = 1'b1;
          end
        end

        S_INT: begin
          int_entry = 1'b1;
          irq_ack   = 1'b1;
          ie_nxt    = 1'b0;
          state_nxt = dbg_halt ? S_HALT : S_FETCH;
        end

        S_HALT: begin
          if (!dbg_halt) begin
            state_nxt = S_FETCH;
          end else if (dbg_step) begin
            state_nxt        = S_FETCH;
            step_pending_nxt = 1'b1;
          end
        end

        default: begin
          state_nxt = S_FETCH;
        end
      endcase

      // Retirement: ie update and boundary decision share the commit cycle
      if (commit) begin
        ie_nxt    = (ie | ie_set) & ~ie_clr;
        state_nxt = bnd_state;
        if (bnd_clr_step) begin
          step_pending_nxt = 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: each stimulus cycle queues its expected
// outputs; a negedge monitor pops and compares.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] inst_in;
  logic       mem_ready, irq, ie_set, ie_clr, dbg_halt, dbg_step;
  logic [7:0] ir;
  logic       cycle, mem_req, fetch, pc_inc, commit, int_entry, irq_ack, ie, halted;

  cpu_sequencer dut (
    .clk(clk), .rst(rst), .inst_in(inst_in), .mem_ready(mem_ready), .irq(irq),
    .ie_set(ie_set), .ie_clr(ie_clr), .dbg_halt(dbg_halt), .dbg_step(dbg_step),
    .ir(ir), .cycle(cycle), .mem_req(mem_req), .fetch(fetch), .pc_inc(pc_inc),
    .commit(commit), .int_entry(int_entry), .irq_ack(irq_ack), .ie(ie),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // input bits: {rst, mem_ready, irq, ie_set, ie_clr, dbg_halt, dbg_step}
  localparam logic [6:0] N      = 7'b0000000;
  localparam logic [6:0] I_RST  = 7'b1000000;
  localparam logic [6:0] I_MR   = 7'b0100000;
  localparam logic [6:0] I_IRQ  = 7'b0010000;
  localparam logic [6:0] I_SET  = 7'b0001000;
  localparam logic [6:0] I_CLR  = 7'b0000100;
  localparam logic [6:0] I_HALT = 7'b0000010;
  localparam logic [6:0] I_STEP = 7'b0000001;

  // output bits: {cycle, ie, halted, mem_req, fetch, pc_inc, commit, int_entry, irq_ack}
  localparam logic [8:0] Z     = 9'b000000000;
  localparam logic [8:0] E_CYC = 9'b100000000;
  localparam logic [8:0] E_IE  = 9'b010000000;
  localparam logic [8:0] E_HLT = 9'b001000000;
  localparam logic [8:0] E_MEM = 9'b000100000;
  localparam logic [8:0] E_FET = 9'b000010000;
  localparam logic [8:0] E_PCI = 9'b000001000;
  localparam logic [8:0] E_COM = 9'b000000100;
  localparam logic [8:0] E_INT = 9'b000000010;
  localparam logic [8:0] E_ACK = 9'b000000001;
  localparam logic [8:0] F     = E_MEM | E_FET | E_PCI;

  typedef struct {
    string      nm;
    logic [7:0] ir;
    logic [8:0] fl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cyc(input string nm, input logic [6:0] in_b, input logic [7:0] din,
                     input logic [7:0] e_ir, input logic [8:0] e_fl);
    exp_t e;
    @(posedge clk);
    #1;
    {rst, mem_ready, irq, ie_set, ie_clr, dbg_halt, dbg_step} = in_b;
    inst_in = din;
    e.nm = nm;
    e.ir = e_ir;
    e.fl = e_fl;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every queued cycle at the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        logic [8:0] act;
        e   = exp_q.pop_front();
        act = {cycle, ie, halted, mem_req, fetch, pc_inc, commit, int_entry, irq_ack};
        checks++;
        if (ir !== e.ir) begin
          errors++;
          $display("FAIL %s ir: got %02h want %02h", e.nm, ir, e.ir);
        end
        checks++;
        if (act !== e.fl) begin
          errors++;
          $display("FAIL %s flags{cyc,ie,hlt,mreq,fet,pci,com,int,ack}: got %09b want %09b",
                   e.nm, act, e.fl);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; inst_in = 8'h00; mem_ready = 1'b0; irq = 1'b0;
    ie_set = 1'b0; ie_clr = 1'b0; dbg_halt = 1'b0; dbg_step = 1'b0;

    cyc("rst0", I_RST, 8'h00, 8'h00, Z);
    cyc("rst1", I_RST, 8'h00, 8'h00, Z);
    // single-cycle, zero wait
    cyc("a_fetch",  I_MR, 8'h45, 8'h00, F);
    cyc("a_exec",   I_MR, 8'h45, 8'h45, E_COM);
    cyc("a_fetch2", I_MR, 8'h45, 8'h45, F);
    cyc("a_exec2",  I_MR, 8'h45, 8'h45, E_COM);
    // two-cycle with waits in both execute cycles
    cyc("b_fetch",  I_MR, 8'h80, 8'h45, F);
    cyc("b_e0w1",   N,    8'h80, 8'h80, E_MEM);
    cyc("b_e0w2",   N,    8'h80, 8'h80, E_MEM);
    cyc("b_e0rdy",  I_MR, 8'h80, 8'h80, E_MEM);
    cyc("b_e1w1",   N,    8'h80, 8'h80, E_CYC | E_MEM);
    cyc("b_e1w2",   N,    8'h80, 8'h80, E_CYC | E_MEM);
    cyc("b_e1w3",   N,    8'h80, 8'h80, E_CYC | E_MEM);
    cyc("b_e1rdy",  I_MR, 8'h80, 8'h80, E_CYC | E_MEM | E_COM);
    // jump: second cycle without memory
    cyc("c_fetch",  I_MR, 8'hE0, 8'h80, F);
    cyc("c_e0",     I_MR, 8'hE0, 8'hE0, E_MEM);
    cyc("c_e1",     I_MR, 8'hE0, 8'hE0, E_CYC | E_COM);
    // interrupt enable ordering
    cyc("d_fetch",   I_MR,                 8'h12, 8'hE0, F);
    cyc("d_sei",     I_MR | I_SET,         8'h12, 8'h12, E_COM);
    cyc("d_fetch2",  I_MR | I_IRQ,         8'h12, 8'h12, E_IE | F);
    cyc("d_cli_irq", I_MR | I_IRQ | I_CLR, 8'h12, 8'h12, E_IE | E_COM);
    cyc("d_masked",  I_MR | I_IRQ,         8'h12, 8'h12, F);
    cyc("d_sei_irq", I_MR | I_IRQ | I_SET, 8'h12, 8'h12, E_COM);
    cyc("d_fetch4",  I_MR | I_IRQ,         8'h12, 8'h12, E_IE | F);
    cyc("d_take",    I_MR | I_IRQ,         8'h12, 8'h12, E_IE | E_COM);
    cyc("d_int",     I_MR | I_IRQ,         8'h12, 8'h12, E_IE | E_INT | E_ACK);
    cyc("d_postint", I_MR,                 8'h12, 8'h12, F);
    cyc("d_exec",    I_MR,                 8'h12, 8'h12, E_COM);
    // debug halt and single step
    cyc("e_fetch",   I_MR | I_HALT,          8'h12, 8'h12, F);
    cyc("e_commit",  I_MR | I_HALT,          8'h12, 8'h12, E_COM);
    cyc("e_halt",    I_MR | I_HALT,          8'h12, 8'h12, E_HLT);
    cyc("e_step",    I_MR | I_HALT | I_STEP, 8'h12, 8'h12, E_HLT);
    cyc("e_sfetch",  I_MR | I_HALT,          8'h45, 8'h12, F);
    cyc("e_scommit", I_MR | I_HALT,          8'h45, 8'h45, E_COM);
    cyc("e_rehalt",  I_MR | I_HALT,          8'h45, 8'h45, E_HLT);
    cyc("e_release", I_MR,                   8'h45, 8'h45, E_HLT);
    cyc("e_run",     I_MR,                   8'h12, 8'h45, F);
    cyc("e_sei",     I_MR | I_SET,           8'h12, 8'h12, E_COM);
    // irq and halt together: INT first, then HALT
    cyc("f_fetch",   I_MR,                  8'h12, 8'h12, E_IE | F);
    cyc("f_commit",  I_MR | I_IRQ | I_HALT, 8'h12, 8'h12, E_IE | E_COM);
    cyc("f_int",     I_MR | I_IRQ | I_HALT, 8'h12, 8'h12, E_IE | E_INT | E_ACK);
    cyc("f_halt",    I_MR | I_HALT,         8'h12, 8'h12, E_HLT);
    cyc("f_release", I_MR,                  8'h12, 8'h12, E_HLT);
    cyc("f_fetch2",  I_MR,                  8'h12, 8'h12, F);
    cyc("f_sei",     I_MR | I_SET,          8'h12, 8'h12, E_COM);
    // reset during EXEC1 stall
    cyc("g_fetch",   I_MR,         8'h80, 8'h12, E_IE | F);
    cyc("g_e0",      I_MR,         8'h80, 8'h80, E_IE | E_MEM);
    cyc("g_e1w1",    N,            8'h80, 8'h80, E_IE | E_CYC | E_MEM);
    cyc("g_rst",     I_RST | I_MR, 8'h80, 8'h80, E_IE | E_CYC);
    cyc("g_fwait",   N,            8'h45, 8'h00, E_MEM | E_FET);
    cyc("g_fetch2",  I_MR,         8'h45, 8'h00, F);
    // dbg_step outside HALT is ignored
    cyc("g_exec_st", I_MR | I_STEP, 8'h45, 8'h45, E_COM);
    cyc("g_fetch3",  I_MR,          8'h45, 8'h45, F);
    cyc("g_exec3",   I_MR,          8'h45, 8'h45, E_COM);
    cyc("g_fetch4",  I_MR,          8'h45, 8'h45, F);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected cycles left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want finish");
    $fatal(1);
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Cycle sequencer for the Nandy core. It fetches instructions into the instruction register and drives the `inst`/`cycle` inputs of the combinational decoder. It stretches cycles while memory is not ready, sequences one-cycle and two-cycle instructions, takes interrupts at instruction boundaries, and provides debug halt and single-step. All per-instruction control strobes remain in the decoder; this block decides only when each cycle happens and when it retires.

Parameters:
TWO_CYC_BIT, 7, bit of the instruction register that marks a two-cycle instruction (inst[7]=1).
MEM_BIT, 6, bit of the instruction register that, when 0 in a two-cycle instruction, marks a second-cycle memory access.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
inst_in  input  8  instruction byte from the memory read bus.
mem_ready  input  1  memory completes the current access this cycle.
irq  input  1  level interrupt request.
ie_set  input  1  decoder request to set interrupt enable; sampled only on commit.
ie_clr  input  1  decoder request to clear interrupt enable (the CLI strobe); sampled only on commit.
dbg_halt  input  1  level debug halt request.
dbg_step  input  1  one-cycle pulse: run exactly one instruction while halted.
ir  output  8  latched instruction; drives the decoder `inst` input.
cycle  output  1  execute-cycle index; drives the decoder `cycle` input.
mem_req  output  1  memory access active this cycle.
fetch  output  1  current access is an instruction fetch from the PC.
pc_inc  output  1  increment the PC this cycle.
commit  output  1  instruction retires; register and flag writes are enabled only while this is high.
int_entry  output  1  force the PC to the interrupt vector and save the return address.
irq_ack  output  1  interrupt acknowledge pulse.
ie  output  1  interrupt enable flag.
halted  output  1  core is in the HALT state.

Behaviour:
- Registered outputs: ir, cycle, ie, halted. Combinational from state and inputs: mem_req, fetch, pc_inc, commit, int_entry, irq_ack.
- Reset: state FETCH, ir=8'h00, cycle=0, ie=0, halted=0, step_pending=0. All strobes read 0 while rst=1.
- rst asserted in any state, including mid-stall, aborts the instruction. No commit occurs.
- States: FETCH, EXEC0, EXEC1, INT, HALT.
- FETCH:
  - mem_req=1, fetch=1.
  - On mem_ready: ir<=inst_in, pc_inc=1, next state EXEC0.
  - Otherwise hold with ir unchanged.
- EXEC0 (cycle=0):
  - If ir[TWO_CYC_BIT]=0: commit=1 this cycle, then go to boundary.
  - If ir[TWO_CYC_BIT]=1: mem_req=1 (operand/immediate access), stall until mem_ready, then EXEC1.
  - commit=0 in every stalled cycle.
- EXEC1 (cycle=1):
  - If ir[MEM_BIT]=0: mem_req=1, stall until mem_ready; commit=1 in the ready cycle.
  - If ir[MEM_BIT]=1: commit=1 immediately (single cycle).
  - Then go to boundary.
- Boundary, evaluated in the commit cycle; priority is top to bottom:
  1. irq & ie & ~ie_clr → INT.
  2. dbg_halt or step_pending → HALT, and clear step_pending.
  3. Otherwise → FETCH.
- Interrupt-enable rules:
  - ie update on commit: ie <= (ie | ie_set) & ~ie_clr. Clear wins when both are asserted.
  - ie_clr masks the interrupt at the same boundary.
  - ie_set takes effect only from the next boundary.
- INT: exactly one cycle. int_entry=1, irq_ack=1, ie<=0. Next state is FETCH, or HALT if dbg_halt.
- HALT:
  - halted=1, mem_req=0.
  - If dbg_halt drops → FETCH.
  - Else if dbg_step=1 → FETCH with step_pending<=1.
  - dbg_step outside HALT is ignored.
- irq is never sampled mid-instruction. An irq that deasserts before the boundary is lost (level-sensitive).
- Back-to-back single-cycle instructions with a zero-wait memory take 2 clocks each (FETCH + EXEC0). Two-cycle instructions take 3 clocks plus wait states.

Test Plan:
1. Single-cycle instruction: rst for 2 clocks; mem_ready=1, inst_in=8'h45 → ir=8'h45 one clock after the fetch. The following clock has commit=1 and cycle=0. pc_inc pulses once per 2 clocks.
2. Two-cycle instruction with waits: inst_in=8'h80, mem_ready low for 2 clocks in EXEC0 and 3 clocks in EXEC1 → cycle stays 0 for 3 clocks, then 1 for 4 clocks. commit is high only in the last clock; total 8 clocks including the fetch.
3. Jump instruction 8'hE0 (two-cycle, MEM_BIT=1) → EXEC1 lasts 1 clock with mem_req=0 and commit=1.
4. Interrupt enable ordering:
   - ie=1, irq=1 during the commit of 8'h12 with ie_clr=1 → no INT, ie=0 afterwards.
   - Repeat with ie_clr=0 → int_entry and irq_ack high for 1 clock, then ie=0 and FETCH.
   - ie_set commit with irq=1 held → INT taken at the following boundary, not the current one.
5. Debug halt and step:
   - dbg_halt=1 → halted=1 after the current commit.
   - Pulse dbg_step → exactly one FETCH/commit, then halted=1 again.
   - Drop dbg_halt → free-running resumes.
   - irq and dbg_halt together at a boundary → INT first, then HALT.
6. Reset mid-operation: assert rst in the second stall clock of EXEC1 → no commit, ir=8'h00, ie=0, state FETCH on release.
